// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM states,
// access owner encoding and byte-strobe width.
package mem_arb_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and RAM port seen by mem_arbiter.
// slave = the arbiter; master = the requesters plus the RAM around it.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  import mem_arb_pkg::*;

  logic              if_req;
  logic [WIDTH-1:0]  if_addr;
  logic [WIDTH-1:0]  if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [WIDTH-1:0]  dm_addr;
  logic [WIDTH-1:0]  dm_wdata;
  logic [STRB_W-1:0] dm_wstrb;
  logic [WIDTH-1:0]  dm_rdata;
  logic              dm_ready;

  logic              mem_en;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [WIDTH-1:0]  mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input round-robin picker. The pointer names the input favoured on a
// contested pick and moves to the other input only when a contested pick is taken.
module rr_pick2 #(
  parameter bit FAVOUR_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic ptr_q;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= FAVOUR_RST;
    end else if (en && (&req)) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port RAM between the
// fetch port and the data port; one access in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic              we_q;
  logic [WIDTH-1:0]  addr_q, wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  if_rdata_q, dm_rdata_q;

  logic [1:0] req, grant;
  logic       pick_en, accept;
  logic       mem_en, mem_we, if_ready, dm_ready, busy;

  assign req     = {bus.dm_req, bus.if_req};
  assign pick_en = (state_q == IDLE);

  rr_pick2 #(.FAVOUR_RST(1'b1)) u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (pick_en),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    if_ready = 1'b0;
    dm_ready = 1'b0;
    busy     = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if_ready = (owner_q == OWN_IF);
        dm_ready = (owner_q == OWN_DM);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetches never write: their latched we, data and strobes are forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_DM;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (accept) begin
        if (grant[1]) begin
          owner_q <= OWN_DM;
          we_q    <= bus.dm_we;
          addr_q  <= bus.dm_addr;
          wdata_q <= bus.dm_wdata;
          wstrb_q <= bus.dm_wstrb;
        end else begin
          owner_q <= OWN_IF;
          we_q    <= 1'b0;
          addr_q  <= bus.if_addr;
          wdata_q <= '0;
          wstrb_q <= '0;
        end
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(LATENCY - 1);
      end else if (state_q == WAIT) begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_IF) if_rdata_q <= bus.mem_rdata;
          else                   dm_rdata_q <= bus.mem_rdata;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.if_ready  = if_ready;
  assign bus.dm_ready  = dm_ready;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = busy;

endmodule
